seq_multiplier_controller: RTL and testbench
============================================

// Module: seq_multiplier_controller
// PURPOSE
//   Control unit for the 24-bit shift-add sequential multiplier datapath.
//   Accepts a start request and sequences the operand load, P clear, and WIDTH add/shift iterations.
//   Signals done when the upper product half sits in the datapath P register.
//   Sits directly above the datapath: drives all its control inputs and consumes its A0 output.
// PARAMETERS
//   WIDTH   24  operand width = number of add/shift iterations
//   CNT_W   5   iteration counter width; must satisfy 2**CNT_W > WIDTH-1
// PORTS
//   clk     in   1  system clock; all state updates on posedge
//   rst     in   1  asynchronous, active-high reset
//   start   in   1  request a multiply; sampled only in IDLE
//   A0      in   1  LSB of datapath A register (current multiplier bit)
//   loadA   out  1  load operand A into datapath A register
//   loadB   out  1  load operand B into datapath B register
//   initP   out  1  clear datapath P register
//   loadP   out  1  P <= (Bsel ? B : 0) + P, upper 24 bits
//   shiftA  out  1  A <= {sum bit0, A[23:1]}
//   Bsel    out  1  select B (1) or zero (0) as the adder operand
//   busy    out  1  high from INIT through DONE inclusive
//   done    out  1  one-cycle pulse: datapath result is valid
// BEHAVIOUR
//   States: IDLE, INIT, ITER, DONE. Binary encoded, registered state, async reset to IDLE.
//   IDLE: all outputs 0. start=1 at a clock edge -> INIT; otherwise stay.
//   INIT: loadA=loadB=initP=1, busy=1; counter <= 0; -> ITER unconditionally.
//   ITER: loadP=shiftA=1, busy=1, Bsel=A0 (combinational, Mealy); counter <= counter+1.
//         Exit to DONE on the edge where counter==WIDTH-1, giving exactly WIDTH ITER cycles.
//   DONE: done=1, busy=1 for one cycle; -> IDLE unconditionally.
//   Latency: start sampled at edge k -> INIT cycle k+1 -> ITER k+2..k+WIDTH+1 -> done high in cycle k+WIDTH+2.
//     With WIDTH=24, done is high 26 cycles after the start edge.
//   Throughput: start held high restarts from IDLE, giving one op per WIDTH+3 cycles.
//   start outside IDLE is ignored, not queued.
//   Outside ITER: Bsel=0 and counter is held. Counter value in IDLE/DONE is don't-care to consumers.
//   Exclusivity invariants, never violated:
//     - loadA and shiftA never both 1.
//     - initP and loadP never both 1.
//     - done implies no datapath control active.
//   Result hold: after DONE, the datapath P register holds its value until the next INIT.
//     The controller asserts no loadP/initP while in IDLE.
//   Reset mid-operation: state=IDLE, counter=0, all outputs 0 immediately (async).
//     No done pulse for the aborted op.
//   Reset values: loadA=loadB=initP=loadP=shiftA=Bsel=busy=done=0.
//   A0 is used only in ITER. X on A0 outside ITER must not propagate to any output.
// STRUCTURE
//   Shared package seq_mult_pkg:
//     - MULT_WIDTH=24 and matching CNT_W.
//     - State encodings S_IDLE=2'd0, S_INIT=2'd1, S_ITER=2'd2, S_DONE=2'd3.
//     - Used by this block, the datapath wrapper and the bench.
//   One sub-module: seq_mult_bit_counter (CNT_W-bit counter).
//     - Inputs: clr (sync), en.
//     - Output: last = (count==WIDTH-1).
//   FSM next-state and output decode stay in this module.
//   Top-level pairing (controller + datapath) is a separate wrapper, not part of this block.
// TESTING
//   1 Reset: rst pulse mid-ITER (cycle 10) -> all outputs 0 same cycle, no done; next start runs full 26-cycle op.
//   2 Controller alone: start 1 cycle, A0 tied 1 -> exactly 24 loadP/shiftA cycles with Bsel=1.
//     Checks: 1 INIT cycle; done high at cycle 26 for 1 cycle; busy high cycles 1..26.
//   3 Integrated with datapath, A=B=24'h800000 -> result 24'h400000 on done.
//   4 Integrated, A=B=24'hFFFFFF -> result 24'hFFFFFE on done.
//   5 Integrated, A=24'h000003, B=24'h000005 -> result 24'h000000; A=0 gives Bsel=0 every ITER cycle.
//   6 start held high 3 ops -> 3 done pulses spaced 27 cycles; start pulses during busy -> no extra ops.
//   Bench assertions throughout: exclusivity invariants, done one cycle wide, busy falls the cycle after done.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the 24-bit shift-add sequential multiplier.
// Used by the controller, its iteration counter, the datapath wrapper
// and the bench.
//   MULT_WIDTH : operand width = number of add/shift iterations
//   CNT_W      : iteration counter width (2**CNT_W > MULT_WIDTH-1)
//   state_e    : controller state encoding
package seq_mult_pkg;

    localparam int unsigned MULT_WIDTH = 24;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_mult_bit_counter.sv
// Iteration counter for the sequential multiplier controller.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset (count -> 0)
//   clr  in  synchronous clear, has priority over en
//   en   in  count enable
//   last out high while count == WIDTH-1
module seq_mult_bit_counter #(
    parameter int unsigned WIDTH = seq_mult_pkg::MULT_WIDTH,
    parameter int unsigned CNT_W = seq_mult_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_multiplier_controller.sv
// Control unit for the 24-bit shift-add sequential multiplier datapath.
// Sequences operand load / P clear (INIT), WIDTH add-shift iterations
// (ITER) and a one-cycle done pulse (DONE).
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   start  in  multiply request, sampled only in IDLE
//   A0     in  LSB of datapath A register (current multiplier bit)
//   loadA  out load operand A        loadB  out load operand B
//   initP  out clear P               loadP  out P <= (Bsel?B:0)+P upper half
//   shiftA out shift A with sum bit0 Bsel   out adder operand select (Mealy)
//   busy   out high INIT..DONE       done   out one-cycle result-valid pulse
module seq_multiplier_controller #(
    parameter int unsigned WIDTH = seq_mult_pkg::MULT_WIDTH,
    parameter int unsigned CNT_W = seq_mult_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic A0,
    output logic loadA,
    output logic loadB,
    output logic initP,
    output logic loadP,
    output logic shiftA,
    output logic Bsel,
    output logic busy,
    output logic done
);

    import seq_mult_pkg::*;

    state_e state_q;
    logic   loadA_q, loadB_q, initP_q, loadP_q, shiftA_q, busy_q, done_q;
    logic   last;

    seq_mult_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == S_INIT),
        .en   (state_q == S_ITER),
        .last (last)
    );

    // Outputs are registered alongside the state: each transition loads
    // the output pattern of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            loadA_q  <= 1'b0;
            loadB_q  <= 1'b0;
            initP_q  <= 1'b0;
            loadP_q  <= 1'b0;
            shiftA_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_INIT;
                        loadA_q <= 1'b1;
                        loadB_q <= 1'b1;
                        initP_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_INIT: begin
                    state_q  <= S_ITER;
                    loadA_q  <= 1'b0;
                    loadB_q  <= 1'b0;
                    initP_q  <= 1'b0;
                    loadP_q  <= 1'b1;
                    shiftA_q <= 1'b1;
                end
                S_ITER: begin
                    if (last) begin
                        state_q  <= S_DONE;
                        loadP_q  <= 1'b0;
                        shiftA_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign loadA  = loadA_q;
    assign loadB  = loadB_q;
    assign initP  = initP_q;
    assign loadP  = loadP_q;
    assign shiftA = shiftA_q;
    assign busy   = busy_q;
    assign done   = done_q;
    // Gated by state so an unknown A0 outside ITER never reaches Bsel.
    assign Bsel   = (state_q == S_ITER) & A0;

endmodule

// File: tb/tb_seq_multiplier_controller.sv
`timescale 1ns/1ps
module tb_seq_multiplier_controller;
    import seq_mult_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic A0;
    logic loadA, loadB, initP, loadP, shiftA, Bsel, busy, done;

    always #5 clk = ~clk;

    seq_multiplier_controller #(
        .WIDTH (MULT_WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A0     (A0),
        .loadA  (loadA),
        .loadB  (loadB),
        .initP  (initP),
        .loadP  (loadP),
        .shiftA (shiftA),
        .Bsel   (Bsel),
        .busy   (busy),
        .done   (done)
    );

    // Behavioural datapath model
    logic [23:0] opA = '0, opB = '0;
    logic [23:0] dpA, dpB, dpP;
    logic [24:0] sum;
    bit          a0_force = 1'b0;

    assign A0  = a0_force ? 1'b1 : dpA[0];
    assign sum = {1'b0, (Bsel ? dpB : 24'd0)} + {1'b0, dpP};

    always @(posedge clk) begin
        if (loadA) dpA <= opA;
        else if (shiftA) dpA <= {sum[0], dpA[23:1]};
        if (loadB) dpB <= opB;
        if (initP) dpP <= '0;
        else if (loadP) dpP <= sum[24:1];
    end

    // {loadA,loadB,initP,loadP,shiftA,Bsel,busy,done}
    logic [7:0] outv;
    assign outv = {loadA, loadB, initP, loadP, shiftA, Bsel, busy, done};
    localparam logic [7:0] EXP_IDLE = 8'b0000_0000;
    localparam logic [7:0] EXP_INIT = 8'b1110_0010;
    localparam logic [7:0] EXP_DONE = 8'b0000_0011;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_seen = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] p;
        p = {24'd0, a} * {24'd0, b};
        return p[47:24];
    endfunction

    // Scoreboard + invariant monitor
    typedef struct {
        bit          chk;
        logic [23:0] exp;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        check("invariants",
              {27'd0, loadA & shiftA, initP & loadP,
               done & (loadA | loadB | initP | loadP | shiftA | Bsel),
               prev_done & done, prev_done & busy}, 32'd0);
        if (done) begin
            done_seen++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                if (mon_e.chk) check("product", dpP, mon_e.exp);
            end
        end
        prev_done = done;
    end

    // One full operation with cycle-by-cycle control checks
    task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic [23:0] exp,
                          input bit frc, input int exp_bsel);
        sb_t e;
        int nb;
        logic [7:0] ev;
        nb = 0;
        @(negedge clk);
        opA = a; opB = b; a0_force = frc; start = 1'b1;
        e.chk = !frc; e.exp = exp;
        sb.push_back(e);
        for (int n = 1; n <= 27; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 1) ev = EXP_INIT;
            else if (n <= 25) ev = {5'b00011, A0, 2'b10};
            else if (n == 26) ev = EXP_DONE;
            else ev = EXP_IDLE;
            check($sformatf("ctl_a%06h_n%0d", a, n), 32'(outv), 32'(ev));
            if (n >= 2 && n <= 25 && Bsel) nb++;
        end
        check($sformatf("bsel_count_a%06h", a), nb, exp_bsel);
    endtask

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] exp;
        bit          frc;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int cnt;
        int dc[3];
        int d0;
        logic [23:0] ra, rb;

        ra = 24'($urandom);
        rb = 24'($urandom);
        vecs[0] = '{24'h123456, 24'h654321, 24'h000000, 1'b1};
        vecs[1] = '{24'h800000, 24'h800000, 24'h400000, 1'b0};
        vecs[2] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b0};
        vecs[3] = '{24'h000003, 24'h000005, 24'h000000, 1'b0};
        vecs[4] = '{24'h000000, 24'hFFFFFF, 24'h000000, 1'b0};
        vecs[5] = '{24'hFFFFFF, 24'h000002, 24'h000001, 1'b0};
        vecs[6] = '{24'h400000, 24'h000008, 24'h000002, 1'b0};
        vecs[7] = '{ra, rb, ref_mul(ra, rb), 1'b0};
        vecs[8] = '{rb, 24'hA5A5A5, ref_mul(rb, 24'hA5A5A5), 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outv), 32'(EXP_IDLE));
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", 32'(outv), 32'(EXP_IDLE));

        // Table-driven operations (entry 0: A0 forced high)
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].frc,
                   vecs[i].frc ? 24 : $countones(vecs[i].a));
        end
        a0_force = 1'b0;

        // Async reset mid-ITER aborts the op without a done pulse
        @(negedge clk);
        opA = 24'h00F00F; opB = 24'h0ABCDE; start = 1'b1;
        sb.push_back('{1'b1, ref_mul(24'h00F00F, 24'h0ABCDE)});
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_iter", {29'd0, loadP, shiftA, busy}, 32'd7);
        #2 rst = 1'b1;
        #1;
        check("reset_async_outs", 32'(outv), 32'(EXP_IDLE));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        d0 = done_seen;
        repeat (30) @(negedge clk);
        check("no_done_after_abort", done_seen - d0, 0);
        run_op(24'h00F00F, 24'h0ABCDE, ref_mul(24'h00F00F, 24'h0ABCDE), 1'b0,
               $countones(24'h00F00F));

        // start held high: back-to-back ops every WIDTH+3 cycles
        @(negedge clk);
        opA = 24'hF0F0F0; opB = 24'h0FF00F; start = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back('{1'b1, ref_mul(24'hF0F0F0, 24'h0FF00F)});
        cnt = 0;
        for (int i = 0; i < 120 && cnt < 3; i++) begin
            @(negedge clk);
            if (done) begin
                dc[cnt] = cyc;
                cnt++;
            end
        end
        start = 1'b0;
        check("held_done_count", cnt, 3);
        if (cnt == 3) begin
            check("held_spacing1", dc[1] - dc[0], 27);
            check("held_spacing2", dc[2] - dc[1], 27);
        end

        // start pulses while busy are ignored
        repeat (3) @(negedge clk);
        opA = 24'h0000FF; opB = 24'h00FF00; start = 1'b1;
        sb.push_back('{1'b1, ref_mul(24'h0000FF, 24'h00FF00)});
        cnt = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            start = (n == 5 || n == 15 || n == 26);
            if (done) cnt++;
        end
        start = 1'b0;
        check("pulse_done_count", cnt, 1);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
